// File: rtl/gpio_pad_cond.sv
// GPIO pad conditioning: per-pin synchroniser, debouncer and edge interrupts on the
// input side, plus mode-decoded output enable / value on the drive side.
module gpio_pad_cond #(
  parameter int          NUM_PINS   = 2,
  parameter logic [15:0] DEB_CYCLES = 16'd1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         reg_ctrl_i,
  input  logic [31:0]         reg_data_i,
  input  logic [NUM_PINS-1:0] pad_i,
  output logic [NUM_PINS-1:0] pad_o,
  output logic [NUM_PINS-1:0] pad_oe_o,
  output logic [NUM_PINS-1:0] io_pin_o,
  input  logic [NUM_PINS-1:0] rise_en_i,
  input  logic [NUM_PINS-1:0] fall_en_i,
  input  logic [NUM_PINS-1:0] irq_clr_i,
  output logic [NUM_PINS-1:0] irq_pending_o,
  output logic                irq_o
);

  // A zero debounce length degenerates to a single-cycle acceptance.
  localparam logic [15:0] DEB_MAX = (DEB_CYCLES == 16'd0) ? 16'd0 : (DEB_CYCLES - 16'd1);

  logic [NUM_PINS-1:0] s1_r;
  logic [NUM_PINS-1:0] s2_r;
  logic [NUM_PINS-1:0] stable_r;
  logic [NUM_PINS-1:0] pending_r;
  logic [15:0]         cnt_r [NUM_PINS];

  logic [NUM_PINS-1:0] in_mode_s;
  logic [NUM_PINS-1:0] rise_s;
  logic [NUM_PINS-1:0] fall_s;
  logic [NUM_PINS-1:0] set_s;
  logic                unused_regs_s;

  assign unused_regs_s = ^{reg_ctrl_i, reg_data_i};

  // Mode decode: drive the pad only in output mode; reserved mode stays hi-Z.
  always_comb begin
    pad_o     = '0;
    pad_oe_o  = '0;
    in_mode_s = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      case (reg_ctrl_i[2*i +: 2])
        2'd1: begin
          pad_oe_o[i]  = 1'b1;
          pad_o[i]     = reg_data_i[i];
          in_mode_s[i] = 1'b0;
        end
        2'd2: begin
          pad_oe_o[i]  = 1'b0;
          pad_o[i]     = 1'b0;
          in_mode_s[i] = 1'b1;
        end
        default: begin
          pad_oe_o[i]  = 1'b0;
          pad_o[i]     = 1'b0;
          in_mode_s[i] = 1'b0;
        end
      endcase
    end
  end

  // Edge pulses coincide with the cycle the debounced level is accepted.
  always_comb begin
    rise_s = '0;
    fall_s = '0;
    set_s  = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if ((s2_r[i] != stable_r[i]) && (cnt_r[i] == DEB_MAX)) begin
        rise_s[i] = s2_r[i];
        fall_s[i] = ~s2_r[i];
      end else begin
        rise_s[i] = 1'b0;
        fall_s[i] = 1'b0;
      end
      set_s[i] = in_mode_s[i] & ((rise_s[i] & rise_en_i[i]) | (fall_s[i] & fall_en_i[i]));
    end
  end

  // Synchroniser, debounce counters and sticky pending bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r      <= '0;
      s2_r      <= '0;
      stable_r  <= '0;
      pending_r <= '0;
      for (int i = 0; i < NUM_PINS; i++) begin
        cnt_r[i] <= 16'd0;
      end
    end else begin
      s1_r <= pad_i;
      s2_r <= s1_r;
      for (int i = 0; i < NUM_PINS; i++) begin
        if (s2_r[i] == stable_r[i]) begin
          cnt_r[i] <= 16'd0;
        end else if (cnt_r[i] == DEB_MAX) begin
          stable_r[i] <= s2_r[i];
          cnt_r[i]    <= 16'd0;
        end else begin
          cnt_r[i] <= cnt_r[i] + 16'd1;
        end
        // A new edge wins over a simultaneous clear strobe.
        if (set_s[i]) begin
          pending_r[i] <= 1'b1;
        end else if (irq_clr_i[i]) begin
          pending_r[i] <= 1'b0;
        end else begin
          pending_r[i] <= pending_r[i];
        end
      end
    end
  end

  assign io_pin_o      = stable_r;
  assign irq_pending_o = pending_r;
  assign irq_o         = |pending_r;

endmodule

// File: tb/tb_gpio_pad_cond.sv
// Directed self-checking bench for gpio_pad_cond with NUM_PINS=2, DEB_CYCLES=4.
module tb_gpio_pad_cond;

  logic        clk;
  logic        rst;
  logic [31:0] reg_ctrl_i;
  logic [31:0] reg_data_i;
  logic [1:0]  pad_i;
  logic [1:0]  pad_o;
  logic [1:0]  pad_oe_o;
  logic [1:0]  io_pin_o;
  logic [1:0]  rise_en_i;
  logic [1:0]  fall_en_i;
  logic [1:0]  irq_clr_i;
  logic [1:0]  irq_pending_o;
  logic        irq_o;

  int checks;
  int failures;

  gpio_pad_cond #(.NUM_PINS(2), .DEB_CYCLES(16'd4)) dut (
    .clk           (clk),
    .rst           (rst),
    .reg_ctrl_i    (reg_ctrl_i),
    .reg_data_i    (reg_data_i),
    .pad_i         (pad_i),
    .pad_o         (pad_o),
    .pad_oe_o      (pad_oe_o),
    .io_pin_o      (io_pin_o),
    .rise_en_i     (rise_en_i),
    .fall_en_i     (fall_en_i),
    .irq_clr_i     (irq_clr_i),
    .irq_pending_o (irq_pending_o),
    .irq_o         (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; reg_ctrl_i = 32'hA; reg_data_i = 32'h0;
    rise_en_i = 2'b11; fall_en_i = 2'b11; irq_clr_i = 2'b00; pad_i = 2'b00;
    for (int k = 0; k < 8; k++) begin
      pad_i = ~pad_i;
      tick();
      checks++;
      if ({io_pin_o, irq_pending_o, irq_o, pad_oe_o, pad_o} !== 9'd0) begin
        failures++;
        $display("FAIL reset_hold: io=%b pend=%b irq=%b oe=%b o=%b expected all 0",
                 io_pin_o, irq_pending_o, irq_o, pad_oe_o, pad_o);
      end
    end
    pad_i = 2'b00;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if ({io_pin_o, irq_pending_o, irq_o} !== 5'd0) begin
      failures++;
      $display("FAIL reset_release: io=%b pend=%b irq=%b expected 0", io_pin_o, irq_pending_o, irq_o);
    end
  endtask

  task automatic test_output_drive();
    reg_ctrl_i = 32'h9; reg_data_i = 32'h3; #1;
    checks++;
    if (pad_oe_o !== 2'b01 || pad_o !== 2'b01) begin
      failures++;
      $display("FAIL drive_9_3: oe=%b o=%b expected oe=01 o=01", pad_oe_o, pad_o);
    end
    reg_data_i = 32'h2; #1;
    checks++;
    if (pad_oe_o !== 2'b01 || pad_o !== 2'b00) begin
      failures++;
      $display("FAIL drive_9_2: oe=%b o=%b expected oe=01 o=00", pad_oe_o, pad_o);
    end
    reg_ctrl_i = 32'hF; reg_data_i = 32'h3; #1;
    checks++;
    if (pad_oe_o !== 2'b00 || pad_o !== 2'b00) begin
      failures++;
      $display("FAIL drive_F: oe=%b o=%b expected oe=00 o=00", pad_oe_o, pad_o);
    end
    reg_ctrl_i = 32'h4; reg_data_i = 32'h2; #1;
    checks++;
    if (pad_oe_o !== 2'b10 || pad_o !== 2'b10) begin
      failures++;
      $display("FAIL drive_4_2: oe=%b o=%b expected oe=10 o=10", pad_oe_o, pad_o);
    end
    reg_ctrl_i = 32'h5; reg_data_i = 32'h1; #1;
    checks++;
    if (pad_oe_o !== 2'b11 || pad_o !== 2'b01) begin
      failures++;
      $display("FAIL drive_5_1: oe=%b o=%b expected oe=11 o=01", pad_oe_o, pad_o);
    end
    tick();
  endtask

  task automatic test_debounce();
    reg_ctrl_i = 32'h8; reg_data_i = 32'h0; rise_en_i = 2'b00; fall_en_i = 2'b00;
    pad_i[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (io_pin_o[1] !== 1'b0) begin
        failures++;
        $display("FAIL deb_early cycle %0d: io1=%b expected 0", k, io_pin_o[1]);
      end
    end
    tick();
    checks++;
    if (io_pin_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL deb_latency: io1=%b expected 1 after 6 edges", io_pin_o[1]);
    end
    pad_i[1] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (io_pin_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL deb_fall: io1=%b expected 0", io_pin_o[1]);
    end
    pad_i[1] = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    pad_i[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (io_pin_o[1] !== 1'b0) begin
        failures++;
        $display("FAIL deb_glitch cycle %0d: io1=%b expected 0", k, io_pin_o[1]);
      end
    end
    checks++;
    if (irq_pending_o !== 2'b00) begin
      failures++;
      $display("FAIL deb_no_irq: pend=%b expected 00", irq_pending_o);
    end
  endtask

  task automatic test_rise_irq();
    rise_en_i = 2'b10; fall_en_i = 2'b00; reg_ctrl_i = 32'h8;
    pad_i[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (irq_pending_o !== 2'b00 || irq_o !== 1'b0) begin
        failures++;
        $display("FAIL rise_early cycle %0d: pend=%b irq=%b expected 00/0", k, irq_pending_o, irq_o);
      end
    end
    tick();
    checks++;
    if (io_pin_o[1] !== 1'b1 || irq_pending_o !== 2'b10 || irq_o !== 1'b1) begin
      failures++;
      $display("FAIL rise_set: io1=%b pend=%b irq=%b expected 1/10/1", io_pin_o[1], irq_pending_o, irq_o);
    end
    pad_i[1] = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (io_pin_o[1] !== 1'b0 || irq_pending_o !== 2'b10) begin
      failures++;
      $display("FAIL fall_disabled: io1=%b pend=%b expected 0/10", io_pin_o[1], irq_pending_o);
    end
  endtask

  task automatic test_clear_collision();
    irq_clr_i = 2'b10;
    tick();
    irq_clr_i = 2'b00;
    checks++;
    if (irq_pending_o !== 2'b00 || irq_o !== 1'b0) begin
      failures++;
      $display("FAIL clear: pend=%b irq=%b expected 00/0", irq_pending_o, irq_o);
    end
    pad_i[1] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    irq_clr_i = 2'b10;
    tick();
    irq_clr_i = 2'b00;
    checks++;
    if (io_pin_o[1] !== 1'b1 || irq_pending_o !== 2'b10) begin
      failures++;
      $display("FAIL set_beats_clear: io1=%b pend=%b expected 1/10", io_pin_o[1], irq_pending_o);
    end
    tick();
    checks++;
    if (irq_pending_o !== 2'b10 || irq_o !== 1'b1) begin
      failures++;
      $display("FAIL set_holds: pend=%b irq=%b expected 10/1", irq_pending_o, irq_o);
    end
  endtask

  task automatic test_mode_gating();
    reg_ctrl_i = 32'h1; reg_data_i = 32'h1; rise_en_i = 2'b01; fall_en_i = 2'b01;
    pad_i[0] = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (io_pin_o[0] !== 1'b1 || irq_pending_o !== 2'b10 || pad_oe_o !== 2'b01 || pad_o !== 2'b01) begin
      failures++;
      $display("FAIL gate_rise: io0=%b pend=%b oe=%b o=%b expected 1/10/01/01",
               io_pin_o[0], irq_pending_o, pad_oe_o, pad_o);
    end
    pad_i[0] = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (io_pin_o[0] !== 1'b0 || irq_pending_o !== 2'b10) begin
      failures++;
      $display("FAIL gate_fall: io0=%b pend=%b expected 0/10", io_pin_o[0], irq_pending_o);
    end
  endtask

  task automatic test_async_reset();
    reg_ctrl_i = 32'h8; rise_en_i = 2'b10; fall_en_i = 2'b00;
    pad_i[1] = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (io_pin_o !== 2'b00 || irq_pending_o !== 2'b00 || irq_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: io=%b pend=%b irq=%b expected 00/00/0", io_pin_o, irq_pending_o, irq_o);
    end
    pad_i[1] = 1'b1;
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (io_pin_o[1] !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_early cycle %0d: io1=%b expected 0", k, io_pin_o[1]);
      end
    end
    tick();
    checks++;
    if (io_pin_o[1] !== 1'b1 || irq_pending_o !== 2'b10) begin
      failures++;
      $display("FAIL post_reset_accept: io1=%b pend=%b expected 1/10", io_pin_o[1], irq_pending_o);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_output_drive();
    test_debounce();
    test_rise_irq();
    test_clear_collision();
    test_mode_gating();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_pad_cond.md
Name: gpio_pad_cond

Overview:
- Pin-side stage between the GPIO register block and the chip pads.
- Input path: synchronises, debounces and edge-detects raw pad inputs, then feeds the clean levels to the GPIO register block's io_pin_i.
- Output path: turns the register block's per-pin 2-bit mode field and data register into pad output-enable and pad output values.
- Raises a sticky edge interrupt for the core interrupt controller.

Parameters:
- NUM_PINS, 2, number of pads handled; must be 1..16.
- DEB_CYCLES, 16'd1000, consecutive stable clk cycles a synchronised input must hold before it is accepted; 0 behaves as 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- reg_ctrl_i  input  32  GPIO ctrl register; bits [2i+1:2i] are the mode of pin i: 0 hi-Z, 1 output, 2 input, 3 reserved (treated as hi-Z).
- reg_data_i  input  32  GPIO data register; bit i is the output value of pin i.
- pad_i  input  NUM_PINS  raw asynchronous pad inputs.
- pad_o  output  NUM_PINS  pad output values.
- pad_oe_o  output  NUM_PINS  pad output enables; 1 means drive.
- io_pin_o  output  NUM_PINS  debounced levels; connects to the GPIO register block io_pin_i.
- rise_en_i  input  NUM_PINS  rising-edge interrupt enables.
- fall_en_i  input  NUM_PINS  falling-edge interrupt enables.
- irq_clr_i  input  NUM_PINS  one-cycle clear strobes for the pending bits.
- irq_pending_o  output  NUM_PINS  sticky pending bits.
- irq_o  output  1  OR of irq_pending_o.

Behaviour:
- Reset (rst=0, asynchronous):
  - Sync flops, debounced state, counters and pending bits all go to 0.
  - Outputs: pad_o=0, pad_oe_o=0, io_pin_o=0, irq_pending_o=0, irq_o=0.
  - Reset asserted mid-debounce aborts the count; nothing carries over after release.
- Output path (combinational, per pin i):
  - Mode 1: pad_oe_o[i]=1, pad_o[i]=reg_data_i[i].
  - Modes 0, 2 and 3: pad_oe_o[i]=0, pad_o[i]=0.
  - Mode changes take effect in the same cycle; there are no glitch-filter registers on this path.
- Synchroniser: per pin, two flops s1<=pad_i, s2<=s1. All downstream logic uses only s2.
- Debouncer (per pin; holds stable[i] and cnt[i], 16 bits):
  - s2==stable: cnt<=0.
  - s2!=stable and cnt==max(DEB_CYCLES,1)-1: stable<=s2, cnt<=0, and a one-cycle edge pulse fires (rise if s2=1, fall if s2=0).
  - s2!=stable otherwise: cnt<=cnt+1.
  - Any cycle with s2==stable restarts the count. A glitch shorter than DEB_CYCLES is never accepted.
  - Latency from a pad change to io_pin_o: 2 + DEB_CYCLES posedges (2 + 1 when DEB_CYCLES is 0).
  - io_pin_o=stable, registered. The debouncer runs in every mode.
- Interrupts (per pin):
  - set[i] = mode==2 AND ((rise pulse AND rise_en_i[i]) OR (fall pulse AND fall_en_i[i])).
  - pending[i] <= set ? 1 : (irq_clr_i[i] ? 0 : pending).
  - Set wins over a simultaneous clear.
  - Edges in modes 0, 1 and 3 never set pending.
  - Changing an enable or the mode does not affect bits already pending.
  - irq_o is registered-equivalent: the OR of the registered pending bits, no combinational path from pad_i.
- The counter saturates by construction (it never exceeds DEB_CYCLES-1), so there is no wrap-around.

Test Plan:
- Reset: hold rst=0 with pad_i toggling -> all outputs 0. Release with pad_i=2'b00 -> io_pin_o stays 0 and no irq.
- Output drive, NUM_PINS=2: reg_ctrl_i=0x9 (pin0 output, pin1 input), reg_data_i=0x3 -> pad_oe_o=2'b01, pad_o=2'b01. Set reg_ctrl_i=0xF -> pad_oe_o=0.
- Debounce, DEB_CYCLES=4, pin1 in input mode: step pad_i[1] 0->1 -> io_pin_o[1] rises exactly 6 posedges later. Separately, a 3-cycle high pulse -> io_pin_o[1] stays 0.
- Rise interrupt, rise_en_i=2'b10, mode 2 on pin1: pad_i[1] goes high and is held -> irq_pending_o=2'b10 and irq_o=1 in the cycle io_pin_o[1] rises. A later fall with fall_en_i=0 -> no change.
- Clear/set collision: pending[1]=1, pulse irq_clr_i[1] -> pending 0 next cycle. Then pulse irq_clr_i[1] in the same cycle as a new enabled edge -> pending stays 1.
- Mode gating and async reset: pin0 in mode 1 with fall_en_i[0]=1, pad_i[0] falls -> io_pin_o[0] follows, pending stays 0. Then assert rst mid-count on pin1 -> cnt and io_pin_o clear immediately without waiting for clk.
